// File: rtl/meduram_bist_pkg.sv
// rtl/meduram_bist_pkg.sv - shared types, constants and pattern function for the meduram BIST
package meduram_bist_pkg;

  localparam int MAX_RD_LATENCY = 4;
  localparam int MAX_DATA_WIDTH = 64;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } bist_state_e;

  // Address-derived test word; callers cast the result down to their data width.
  function automatic logic [MAX_DATA_WIDTH-1:0] bist_pattern(
    input logic [MAX_DATA_WIDTH-1:0] seed,
    input logic [MAX_DATA_WIDTH-1:0] addr,
    input logic                      invert
  );
    logic [MAX_DATA_WIDTH-1:0] sum;
    sum = seed + addr;
    return invert ? ~sum : sum;
  endfunction

endpackage

// File: rtl/meduram_bist_checker.sv
// rtl/meduram_bist_checker.sv - read-data checker: expected-address pipeline, compare, error statistics
module meduram_bist_checker
  import meduram_bist_pkg::*;
#(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int RD_LATENCY    = 1,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     clear,
  input  logic                     rd_issue,
  input  logic [ADDR_WIDTH-1:0]    rd_addr,
  input  logic [DATA_WIDTH-1:0]    rddata,
  input  logic [DATA_WIDTH-1:0]    seed,
  input  logic                     invert,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic [ADDR_WIDTH-1:0]    err_addr
);

  logic [RD_LATENCY-1:0]    vld_q, vld_d;
  logic [ADDR_WIDTH-1:0]    addr_q [RD_LATENCY];
  logic [ADDR_WIDTH-1:0]    addr_d [RD_LATENCY];
  logic [ERR_CNT_WIDTH-1:0] err_count_q, err_count_d;
  logic [ADDR_WIDTH-1:0]    err_addr_q, err_addr_d;
  logic [DATA_WIDTH-1:0]    exp_data;
  logic                     mismatch;

  // Stage 0 captures the read the RAM samples this edge; the tail lines up with rddata.
  always_comb begin
    vld_d       = vld_q;
    addr_d      = addr_q;
    err_count_d = err_count_q;
    err_addr_d  = err_addr_q;
    exp_data    = DATA_WIDTH'(bist_pattern(MAX_DATA_WIDTH'(seed),
                                           MAX_DATA_WIDTH'(addr_q[RD_LATENCY-1]), invert));
    mismatch    = vld_q[RD_LATENCY-1] && (rddata != exp_data);

    vld_d[0]  = rd_issue & ~clear;
    addr_d[0] = rd_addr;
    for (int i = 1; i < RD_LATENCY; i++) begin
      vld_d[i]  = vld_q[i-1] & ~clear;
      addr_d[i] = addr_q[i-1];
    end

    if (clear) begin
      err_count_d = '0;
      err_addr_d  = '0;
    end else if (mismatch) begin
      if (err_count_q == '0) err_addr_d = addr_q[RD_LATENCY-1];
      if (err_count_q != '1) err_count_d = err_count_q + ERR_CNT_WIDTH'(1);
    end
  end

  // Pipeline and statistics registers; reset drops any in-flight compares.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      vld_q       <= '0;
      err_count_q <= '0;
      err_addr_q  <= '0;
      for (int i = 0; i < RD_LATENCY; i++) addr_q[i] <= '0;
    end else begin
      vld_q       <= vld_d;
      addr_q      <= addr_d;
      err_count_q <= err_count_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign err_count = err_count_q;
  assign err_addr  = err_addr_q;

endmodule

// File: rtl/meduram_bist.sv
// rtl/meduram_bist.sv - meduram write/read BIST initiator; MEDURAM_BIST_INVERT_PASS_EN adds an inverted second pass
module meduram_bist
  import meduram_bist_pkg::*;
#(
  parameter int ADDR_WIDTH    = 8,
  parameter int RAM_DEPTH     = 2**ADDR_WIDTH,
  parameter int DATA_WIDTH    = 32,
  parameter int RD_LATENCY    = 1,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     start,
  input  logic [DATA_WIDTH-1:0]    seed,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic [ADDR_WIDTH-1:0]    err_addr,
  output logic                     wren,
  output logic [ADDR_WIDTH-1:0]    wraddr,
  output logic [DATA_WIDTH-1:0]    wrdata,
  output logic                     rden,
  output logic [ADDR_WIDTH-1:0]    rdaddr,
  input  logic [DATA_WIDTH-1:0]    rddata
);

  localparam int                    DRAIN_W    = $clog2(MAX_RD_LATENCY + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(RAM_DEPTH - 1);
  localparam logic [DRAIN_W-1:0]    DRAIN_LAST = DRAIN_W'(RD_LATENCY);

  bist_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DRAIN_W-1:0]      drain_q, drain_d;
  logic [DATA_WIDTH-1:0]   seed_q, seed_d;
  logic                    pass_q, pass_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    wren_q, wren_d;
  logic                    rden_q, rden_d;
  logic [ADDR_WIDTH-1:0]   wraddr_q, wraddr_d;
  logic [ADDR_WIDTH-1:0]   rdaddr_q, rdaddr_d;
  logic [DATA_WIDTH-1:0]   wrdata_q, wrdata_d;
  logic                    clear;
  logic [ERR_CNT_WIDTH-1:0] chk_err_count;
  logic [ADDR_WIDTH-1:0]   chk_err_addr;
`ifdef MEDURAM_BIST_INVERT_PASS_EN
  logic                    inv_q, inv_d;
`endif

  // Sequencer; outputs are registered copies of the next state so the first write follows start directly.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    seed_d  = seed_q;
    pass_d  = pass_q;
    clear   = 1'b0;
`ifdef MEDURAM_BIST_INVERT_PASS_EN
    inv_d   = inv_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_WRITE;
          cnt_d   = '0;
          seed_d  = seed;
          pass_d  = 1'b0;
          clear   = 1'b1;
`ifdef MEDURAM_BIST_INVERT_PASS_EN
          inv_d   = 1'b0;
`endif
        end
      end
      ST_WRITE: begin
        if (cnt_q == LAST_ADDR) begin
          cnt_d   = '0;
          state_d = ST_READ;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      ST_READ: begin
        if (cnt_q == LAST_ADDR) begin
          cnt_d   = '0;
          drain_d = '0;
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      ST_DRAIN: begin
        // The last compare lands on the edge where drain_q==DRAIN_LAST-1; DONE waits one
        // more edge so pass sees the settled error count.
        drain_d = drain_q + DRAIN_W'(1);
`ifdef MEDURAM_BIST_INVERT_PASS_EN
        if (!inv_q && (drain_q == DRAIN_LAST - DRAIN_W'(1))) begin
          state_d = ST_WRITE;
          cnt_d   = '0;
          inv_d   = 1'b1;
        end else if (drain_q == DRAIN_LAST) begin
          state_d = ST_DONE;
          pass_d  = (chk_err_count == '0);
        end
`else
        if (drain_q == DRAIN_LAST) begin
          state_d = ST_DONE;
          pass_d  = (chk_err_count == '0);
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    wren_d   = (state_d == ST_WRITE);
    rden_d   = (state_d == ST_READ);
    wraddr_d = wren_d ? cnt_d : wraddr_q;
    rdaddr_d = rden_d ? cnt_d : rdaddr_q;
`ifdef MEDURAM_BIST_INVERT_PASS_EN
    wrdata_d = wren_d ? DATA_WIDTH'(bist_pattern(MAX_DATA_WIDTH'(seed_d), MAX_DATA_WIDTH'(cnt_d), inv_d))
                      : wrdata_q;
`else
    wrdata_d = wren_d ? DATA_WIDTH'(bist_pattern(MAX_DATA_WIDTH'(seed_d), MAX_DATA_WIDTH'(cnt_d), 1'b0))
                      : wrdata_q;
`endif
    busy_d   = (state_d == ST_WRITE) || (state_d == ST_READ) || (state_d == ST_DRAIN);
    done_d   = (state_d == ST_DONE);
  end

  // State, counter and registered RAM/status outputs.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      drain_q  <= '0;
      seed_q   <= '0;
      pass_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wren_q   <= 1'b0;
      rden_q   <= 1'b0;
      wraddr_q <= '0;
      rdaddr_q <= '0;
      wrdata_q <= '0;
`ifdef MEDURAM_BIST_INVERT_PASS_EN
      inv_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      drain_q  <= drain_d;
      seed_q   <= seed_d;
      pass_q   <= pass_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wren_q   <= wren_d;
      rden_q   <= rden_d;
      wraddr_q <= wraddr_d;
      rdaddr_q <= rdaddr_d;
      wrdata_q <= wrdata_d;
`ifdef MEDURAM_BIST_INVERT_PASS_EN
      inv_q    <= inv_d;
`endif
    end
  end

  meduram_bist_checker #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .RD_LATENCY    (RD_LATENCY),
    .ERR_CNT_WIDTH (ERR_CNT_WIDTH)
  ) u_checker (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .clear     (clear),
    .rd_issue  (rden_q),
    .rd_addr   (rdaddr_q),
    .rddata    (rddata),
    .seed      (seed_q),
`ifdef MEDURAM_BIST_INVERT_PASS_EN
    .invert    (inv_q),
`else
    .invert    (1'b0),
`endif
    .err_count (chk_err_count),
    .err_addr  (chk_err_addr)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = chk_err_count;
  assign err_addr  = chk_err_addr;
  assign wren      = wren_q;
  assign wraddr    = wraddr_q;
  assign wrdata    = wrdata_q;
  assign rden      = rden_q;
  assign rdaddr    = rdaddr_q;

endmodule
